// File: rtl/game_pkg.sv
// Shared definitions for the ship hit/damage logic: FSM states, counter width and default death level.
package game_pkg;

    localparam int CNT_W              = 4;
    localparam int DEAD_LEVEL_DEFAULT = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ARMED,
        COOLDOWN,
        DEAD
    } state_t;

    // The hit count sticks at its maximum instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == CNT_MAX) ? value : value + CNT_W'(1);
    endfunction

endpackage

// File: rtl/hit_counter_if.sv
// Collision/menu inputs and hit-status outputs of the ship hit counter.
interface hit_counter_if;
    import game_pkg::*;

    logic             hit;
    logic             new_game;
    logic [CNT_W-1:0] signal_counter;
    logic             hit_ack;
    logic             cooldown;
    logic             dead;

    modport master (
        output hit, new_game,
        input  signal_counter, hit_ack, cooldown, dead
    );

    modport slave (
        input  hit, new_game,
        output signal_counter, hit_ack, cooldown, dead
    );

endinterface

// File: rtl/rise_detect.sv
// Rising-edge detector for the collision level.
// Define HIT_SYNC_EN to put a 2-flop synchronizer in front of the detector.
module rise_detect (
    input  logic pclk,
    input  logic rst,
    input  logic hit,
    output logic rise
);

`ifdef HIT_SYNC_EN
    localparam int STAGES = 2;
`else
    localparam int STAGES = 0;
`endif
    localparam int PW = STAGES + 1;

    logic          sampled;
    logic          prev;
    logic [PW-1:0] primed;

`ifdef HIT_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], hit};
        end
    end

    assign sampled = sync_q[1];
`else
    assign sampled = hit;
`endif

    // primed fills with ones so that edges are only reported once prev holds a real post-reset
    // sample; a level already high when reset releases is therefore not taken as an edge.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            prev   <= 1'b0;
            primed <= '0;
        end else begin
            prev   <= sampled;
            primed <= (primed << 1) | PW'(1);
        end
    end

    assign rise = sampled & ~prev & primed[PW-1];

endmodule

// File: rtl/hit_counter.sv
// Ship hit counter: counts accepted collisions, ignores hits during a cooldown window, flags death.
// Define HIT_SYNC_EN to synchronize the hit input (2 extra cycles of latency).
module hit_counter
    import game_pkg::*;
#(
    parameter int COOLDOWN_CYCLES = 65_000_000,
    parameter int DEAD_LEVEL      = DEAD_LEVEL_DEFAULT
) (
    input  logic         pclk,
    input  logic         rst,
    hit_counter_if.slave bus
);

    localparam int            DW        = $clog2(COOLDOWN_CYCLES) + 1;
    localparam logic [DW-1:0] DOWN_LOAD = DW'(COOLDOWN_CYCLES - 1);

    state_t           state;
    logic [DW-1:0]    down_cnt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_inc;
    logic             hit_ack_q;
    logic             cooldown_q;
    logic             dead_q;
    logic             hit_rise;

    rise_detect u_rise_detect (
        .pclk (pclk),
        .rst  (rst),
        .hit  (bus.hit),
        .rise (hit_rise)
    );

    assign count_inc = sat_inc(count);

    // new_game overrides everything, including a hit edge arriving in the same cycle.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state      <= ARMED;
            down_cnt   <= '0;
            count      <= '0;
            hit_ack_q  <= 1'b0;
            cooldown_q <= 1'b0;
            dead_q     <= 1'b0;
        end else begin
            hit_ack_q <= 1'b0;
            if (bus.new_game) begin
                state      <= ARMED;
                down_cnt   <= '0;
                count      <= '0;
                cooldown_q <= 1'b0;
                dead_q     <= 1'b0;
            end else begin
                case (state)
                    ARMED: begin
                        if (hit_rise) begin
                            count     <= count_inc;
                            hit_ack_q <= 1'b1;
                            if (int'(count_inc) == DEAD_LEVEL) begin
                                state  <= DEAD;
                                dead_q <= 1'b1;
                            end else begin
                                state      <= COOLDOWN;
                                cooldown_q <= 1'b1;
                                down_cnt   <= DOWN_LOAD;
                            end
                        end
                    end
                    COOLDOWN: begin
                        if (down_cnt == '0) begin
                            state      <= ARMED;
                            cooldown_q <= 1'b0;
                        end else begin
                            down_cnt <= down_cnt - DW'(1);
                        end
                    end
                    DEAD: begin
                        dead_q <= 1'b1;
                    end
                    default: begin
                        state <= ARMED;
                    end
                endcase
            end
        end
    end

    assign bus.signal_counter = count;
    assign bus.hit_ack        = hit_ack_q;
    assign bus.cooldown       = cooldown_q;
    assign bus.dead           = dead_q;

endmodule

// File: tb/tb_hit_counter.sv
// Bench for hit_counter: directed scenarios plus random hits, scored against a cycle-time model.
module tb_hit_counter;

    localparam int CC = 8;
    localparam int DL = 3;
`ifdef HIT_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    typedef struct {
        int         edge_idx;
        logic [3:0] cnt;
        logic       ack;
        logic       cool;
        logic       dead;
    } exp_t;

    logic pclk = 1'b0;
    logic rst;

    hit_counter_if bus ();

    hit_counter #(
        .COOLDOWN_CYCLES (CC),
        .DEAD_LEVEL      (DL)
    ) dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 pclk = ~pclk;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    bit   hist[$];
    int   m_count;
    int   last_acc;
    bit   m_dead;
    int   accepts = 0;
    int   acks_seen = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_count  = 0;
        m_dead   = 1'b0;
        last_acc = -1000;
    endtask

    // Model: edge k accepts a hit if the level rose (seen LAT cycles late), the ship is alive and
    // more than CC edges have passed since the last accepted hit; cooldown spans edges a..a+CC-1.
    task automatic applyStimulus(input bit h, input bit ng);
        exp_t e;
        int   k;
        bit   rise;
        bus.hit      = h;
        bus.new_game = ng;
        hist.push_back(h);
        k    = hist.size() - 1;
        rise = 1'b0;
        if (k >= LAT + 1) rise = hist[k-LAT] && !hist[k-LAT-1];
        e.ack = 1'b0;
        if (ng) begin
            m_count  = 0;
            m_dead   = 1'b0;
            last_acc = -1000;
        end else if (rise && !m_dead && k > last_acc + CC) begin
            if (m_count < 15) m_count++;
            last_acc = k;
            accepts++;
            e.ack = 1'b1;
            if (m_count == DL) m_dead = 1'b1;
        end
        e.edge_idx = k;
        e.cnt      = 4'(m_count);
        e.cool     = !m_dead && k >= last_acc && k <= last_acc + CC - 1;
        e.dead     = m_dead;
        exp_q.push_back(e);
        @(negedge pclk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
    endtask

    task automatic reset_dut(input bit hold_hit);
        rst          = 1'b0;
        bus.hit      = hold_hit;
        bus.new_game = 1'b0;
        model_reset();
        repeat (3) @(negedge pclk);
        rst = 1'b1;
    endtask

    // Monitor: every scored edge is compared just after it, independent of the stimulus thread.
    initial begin
        exp_t e;
        forever begin
            @(posedge pclk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.signal_counter !== e.cnt || bus.hit_ack !== e.ack ||
                    bus.cooldown !== e.cool || bus.dead !== e.dead) begin
                    errors++;
                    $display("[TB] FAIL outputs edge=%0d: got cnt=%0d ack=%b cool=%b dead=%b, expected cnt=%0d ack=%b cool=%b dead=%b",
                             e.edge_idx, bus.signal_counter, bus.hit_ack, bus.cooldown, bus.dead,
                             e.cnt, e.ack, e.cool, e.dead);
                end
                if (bus.hit_ack === 1'b1) acks_seen++;
            end
        end
    end

    initial begin
        int lat;
        int cool_len;
        bit rnd_hit;
        rst          = 1'b0;
        bus.hit      = 1'b0;
        bus.new_game = 1'b0;
        model_reset();
        @(negedge pclk);

        reset_dut(1'b0);
        checkOutput("reset_count", int'(bus.signal_counter), 0);
        checkOutput("reset_hit_ack", int'(bus.hit_ack), 0);
        checkOutput("reset_cooldown", int'(bus.cooldown), 0);
        checkOutput("reset_dead", int'(bus.dead), 0);
        idle(4);

        $display("[TB] single hit pulse");
        applyStimulus(1'b1, 1'b0);
        lat = 1;
        while (bus.hit_ack !== 1'b1 && lat < 10) begin
            applyStimulus(1'b0, 1'b0);
            lat++;
        end
        checkOutput("ack_latency", lat, LAT + 1);
        checkOutput("count_after_first_hit", int'(bus.signal_counter), 1);
        cool_len = 0;
        while (bus.cooldown === 1'b1 && cool_len < 40) begin
            cool_len++;
            applyStimulus(1'b0, 1'b0);
        end
        checkOutput("cooldown_length", cool_len, CC);

        $display("[TB] hit held high for 20 cycles");
        repeat (20) applyStimulus(1'b1, 1'b0);
        idle(LAT + 2);
        checkOutput("held_high_one_increment", int'(bus.signal_counter), 2);
        idle(CC + 2);

        $display("[TB] hits inside the cooldown window");
        applyStimulus(1'b0, 1'b1);
        idle(2);
        checkOutput("new_game_clear", int'(bus.signal_counter), 0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        idle(LAT + 2);
        checkOutput("window_hits_ignored", int'(bus.signal_counter), 1);
        idle(CC + 2);

        $display("[TB] three spaced hits reach DEAD");
        applyStimulus(1'b0, 1'b1);
        idle(2);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0);
            idle(CC + LAT + 3);
        end
        checkOutput("count_at_death", int'(bus.signal_counter), 3);
        checkOutput("dead_flag", int'(bus.dead), 1);
        applyStimulus(1'b1, 1'b0);
        idle(LAT + 3);
        checkOutput("hit_while_dead_count", int'(bus.signal_counter), 3);
        checkOutput("still_dead", int'(bus.dead), 1);

        $display("[TB] new_game with simultaneous hit edge while DEAD");
        for (int i = 0; i < LAT; i++) applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("ng_count", int'(bus.signal_counter), 0);
        checkOutput("ng_dead", int'(bus.dead), 0);
        checkOutput("ng_hit_ack", int'(bus.hit_ack), 0);
        repeat (2) applyStimulus(1'b1, 1'b0);
        idle(LAT + 2);
        checkOutput("ng_hit_discarded", int'(bus.signal_counter), 0);
        applyStimulus(1'b1, 1'b0);
        idle(LAT + 2);
        checkOutput("armed_after_ng", int'(bus.signal_counter), 1);
        idle(CC + 2);

        $display("[TB] asynchronous reset in the middle of cooldown");
        applyStimulus(1'b1, 1'b0);
        idle(LAT + 3);
        checkOutput("cooldown_before_reset", int'(bus.cooldown), 1);
        #2;
        rst     = 1'b0;
        bus.hit = 1'b1;
        #1;
        checkOutput("async_rst_count", int'(bus.signal_counter), 0);
        checkOutput("async_rst_hit_ack", int'(bus.hit_ack), 0);
        checkOutput("async_rst_cooldown", int'(bus.cooldown), 0);
        checkOutput("async_rst_dead", int'(bus.dead), 0);
        @(negedge pclk);
        model_reset();
        repeat (2) @(negedge pclk);
        rst = 1'b1;
        repeat (5) applyStimulus(1'b1, 1'b0);
        idle(LAT + 2);
        checkOutput("held_through_reset", int'(bus.signal_counter), 0);
        applyStimulus(1'b1, 1'b0);
        idle(LAT + 2);
        checkOutput("first_hit_after_reset", int'(bus.signal_counter), 1);
        idle(CC + 2);

        $display("[TB] random hits");
        rnd_hit = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) rnd_hit = ~rnd_hit;
            applyStimulus(rnd_hit, $urandom_range(0, 39) == 0);
        end
        idle(CC + LAT + 3);

        checkOutput("queue_drained", exp_q.size(), 0);
        checkOutput("ack_count", acks_seen, accepts);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
